// File: rtl/avalon_write_master.sv
// -----------------------------------------------------------------------------
// avalon_write_master
//   Avalon-MM write initiator for the 8-bit-address / 32-bit-data write-only
//   slave port. Commands arrive on a valid/ready port, are queued in a small
//   FIFO, and are issued in order as Avalon-MM writes that honour
//   m_waitrequest. Completed writes are counted. A slave that stalls one write
//   for TIMEOUT consecutive edges causes that write to be abandoned, and a
//   sticky error flag is raised.
//
// Ports
//   clk, rst_in                      clock, asynchronous active-high reset
//   cmd_valid/cmd_ready              command handshake
//   cmd_address, cmd_data            command payload
//   m_address, m_write, m_writedata  Avalon-MM write master outputs
//   m_waitrequest                    slave stall input
//   busy                             transfer in progress or commands queued
//   done_count                       completed writes (wrapping)
//   timeout_err, clr_err             sticky stall-timeout flag and its clear
// -----------------------------------------------------------------------------
module avalon_write_master #(
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned TIMEOUT = 256,
   parameter int unsigned CNT_W   = 16
) (
   input  logic              clk,
   input  logic              rst_in,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [ADDR_W-1:0] cmd_address,
   input  logic [DATA_W-1:0] cmd_data,
   output logic [ADDR_W-1:0] m_address,
   output logic              m_write,
   output logic [DATA_W-1:0] m_writedata,
   input  logic              m_waitrequest,
   output logic              busy,
   output logic [CNT_W-1:0]  done_count,
   output logic              timeout_err,
   input  logic              clr_err
);

   localparam int unsigned PTR_W  = $clog2(DEPTH);
   localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   // Counter value at which the next stalled edge is the TIMEOUT-th one.
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_WRITE = 1'b1;

   logic [ADDR_W+DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]           count_q, count_d;

   logic [0:0]               state_q, state_d;
   logic [ADDR_W-1:0]        addr_q, addr_d;
   logic [DATA_W-1:0]        data_q, data_d;
   logic [WAIT_W-1:0]        wait_q, wait_d;
   logic [CNT_W-1:0]         done_q, done_d;
   logic                     err_q, err_d;

   logic full, empty, push, pop, complete, stall, abort;

   assign full      = (count_q == (PTR_W+1)'(DEPTH));
   assign empty     = (count_q == '0);
   assign cmd_ready = !full && !rst_in;
   assign push      = cmd_valid && cmd_ready;

   assign complete  = (state_q == ST_WRITE) && !m_waitrequest;
   assign stall     = (state_q == ST_WRITE) && m_waitrequest;
   assign abort     = stall && (TIMEOUT != 0) && (wait_q == WAIT_LAST);
   // A pop loads the output registers: from IDLE whenever something is queued,
   // or on the completing edge of a write for back-to-back issue.
   assign pop       = !empty && ((state_q == ST_IDLE) || complete);

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      data_d   = data_q;
      wait_d   = wait_q;
      done_d   = done_q;
      err_d    = err_q && !clr_err;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;

      case (state_q)
         ST_IDLE: begin
            if (pop) state_d = ST_WRITE;
         end
         default: begin
            if (complete) begin
               done_d = done_q + CNT_W'(1);
               if (!pop) state_d = ST_IDLE;
            end else if (abort) begin
               state_d = ST_IDLE;
               err_d   = 1'b1;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
      endcase

      if (pop) begin
         {addr_d, data_d} = mem_q[rd_ptr_q];
         wait_d           = '0;
         rd_ptr_d         = rd_ptr_q + PTR_W'(1);
      end
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);

      case ({push, pop})
         2'b10:   count_d = count_q + (PTR_W+1)'(1);
         2'b01:   count_d = count_q - (PTR_W+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst_in) begin
      if (rst_in) begin
         state_q  <= ST_IDLE;
         addr_q   <= '0;
         data_q   <= '0;
         wait_q   <= '0;
         done_q   <= '0;
         err_q    <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         wait_q   <= wait_d;
         done_q   <= done_d;
         err_q    <= err_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // FIFO storage needs no reset: the pointers and count define its contents.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {cmd_address, cmd_data};
   end

   // m_write is decoded from the state so that reset drops it immediately.
   assign m_write     = (state_q == ST_WRITE);
   assign m_address   = addr_q;
   assign m_writedata = data_q;
   assign busy        = (state_q != ST_IDLE) || !empty;
   assign done_count  = done_q;
   assign timeout_err = err_q;

endmodule

// File: tb/tb_avalon_write_master.sv
// -----------------------------------------------------------------------------
// tb_avalon_write_master
//   Self-checking bench for avalon_write_master (DEPTH=4, TIMEOUT=8, CNT_W=4).
//   A transaction-level reference model (queue of accepted commands plus an
//   in-flight flag and stall count) predicts every cycle's outputs; directed
//   scenarios add explicit checks on top of the per-cycle comparison.
// -----------------------------------------------------------------------------
module tb_avalon_write_master;

   localparam int unsigned ADDR_W  = 8;
   localparam int unsigned DATA_W  = 32;
   localparam int unsigned DEPTH   = 4;
   localparam int unsigned TIMEOUT = 8;
   localparam int unsigned CNT_W   = 4;

   logic              clk = 1'b0;
   logic              rst_in;
   logic              cmd_valid;
   logic              cmd_ready;
   logic [ADDR_W-1:0] cmd_address;
   logic [DATA_W-1:0] cmd_data;
   logic [ADDR_W-1:0] m_address;
   logic              m_write;
   logic [DATA_W-1:0] m_writedata;
   logic              m_waitrequest;
   logic              busy;
   logic [CNT_W-1:0]  done_count;
   logic              timeout_err;
   logic              clr_err;

   always #5 clk = ~clk;

   avalon_write_master #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .TIMEOUT(TIMEOUT),
      .CNT_W  (CNT_W)
   ) dut (
      .clk          (clk),
      .rst_in       (rst_in),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_address  (cmd_address),
      .cmd_data     (cmd_data),
      .m_address    (m_address),
      .m_write      (m_write),
      .m_writedata  (m_writedata),
      .m_waitrequest(m_waitrequest),
      .busy         (busy),
      .done_count   (done_count),
      .timeout_err  (timeout_err),
      .clr_err      (clr_err)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [39:0] q[$];     // accepted, not yet completed or dropped (head may be in flight)
   bit          inflight;
   int          stall_n;
   int          exp_done;
   bit          exp_err;
   int          n_acc  = 0;
   int          n_wcyc = 0;
   bit          mon_en = 0;

   function automatic void model_reset();
      q.delete();
      inflight = 0;
      stall_n  = 0;
      exp_done = 0;
      exp_err  = 0;
   endfunction

   // Check current outputs, then advance the model across the coming edge
   // using the (stable) inputs.
   always @(negedge clk) begin
      int fifo_n;
      bit push;
      bit abort;
      if (mon_en && !rst_in) begin
         fifo_n = q.size() - (inflight ? 1 : 0);
         check("m_write", m_write, inflight);
         if (m_write) n_wcyc++;
         if (inflight && q.size() > 0) begin
            check("m_address", m_address, q[0][39:32]);
            check("m_writedata", m_writedata, q[0][31:0]);
         end
         check("done_count", done_count, exp_done % (1 << CNT_W));
         check("timeout_err", timeout_err, exp_err);
         check("busy", busy, q.size() != 0);
         check("cmd_ready", cmd_ready, fifo_n < DEPTH);

         push  = cmd_valid && (fifo_n < DEPTH);
         abort = 0;
         if (inflight) begin
            if (!m_waitrequest) begin
               void'(q.pop_front());
               exp_done++;
               inflight = (fifo_n > 0);
               stall_n  = 0;
            end else begin
               stall_n++;
               if (stall_n == TIMEOUT) begin
                  void'(q.pop_front());
                  abort    = 1;
                  inflight = 0;
               end
            end
         end else if (fifo_n > 0) begin
            inflight = 1;
            stall_n  = 0;
         end
         if (abort) exp_err = 1;
         else if (clr_err) exp_err = 0;
         if (push) begin
            q.push_back({cmd_address, cmd_data});
            n_acc++;
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit v, input logic [7:0] a, input logic [31:0] d);
      cmd_valid   = v;
      cmd_address = a;
      cmd_data    = d;
   endtask

   task automatic wait_idle(input int max_cyc);
      int k = 0;
      @(negedge clk);
      while (busy && k < max_cyc) begin
         @(negedge clk);
         k++;
      end
      check("idle_wait", busy, 0);
   endtask

   int w0, a0, guard, burst;

   initial begin
      rst_in = 1'b1;
      drive(0, '0, '0);
      m_waitrequest = 1'b0;
      clr_err       = 1'b0;
      #2;
      check("rst_m_write", m_write, 0);
      check("rst_m_address", m_address, 0);
      check("rst_m_writedata", m_writedata, 0);
      check("rst_done", done_count, 0);
      check("rst_err", timeout_err, 0);
      check("rst_busy", busy, 0);
      check("rst_ready", cmd_ready, 0);
      tick();
      tick();
      rst_in = 1'b0;
      model_reset();
      mon_en = 1;
      tick();

      // 1: single write, no stall
      drive(1, 8'h10, 32'hDEADBEEF);
      tick();
      cmd_valid = 0;
      @(negedge clk);
      check("t1_m_write_e0", m_write, 0);
      tick();
      @(negedge clk);
      check("t1_m_write_e1", m_write, 1);
      check("t1_addr", m_address, 8'h10);
      check("t1_data", m_writedata, 32'hDEADBEEF);
      tick();
      @(negedge clk);
      check("t1_m_write_e2", m_write, 0);
      check("t1_done", done_count, 1);
      check("t1_busy", busy, 0);

      // 2: write stalled for 3 cycles
      tick();
      w0 = n_wcyc;
      m_waitrequest = 1;
      drive(1, 8'h04, 32'h12345678);
      tick();
      cmd_valid = 0;
      tick();
      repeat (3) tick();
      m_waitrequest = 0;
      wait_idle(20);
      check("t2_write_cycles", n_wcyc - w0, 4);
      check("t2_done", done_count, 2);

      // 3: fill the queue while stalled, then drain back-to-back
      tick();
      a0 = n_acc;
      w0 = n_wcyc;
      m_waitrequest = 1;
      for (int i = 1; i <= 6; i++) begin
         drive(1, 8'h40 + 8'(i), 32'(i));
         @(negedge clk);
         if (i == 6) check("t3_ready_full", cmd_ready, 0);
         tick();
      end
      cmd_valid = 0;
      m_waitrequest = 0;
      wait_idle(30);
      check("t3_accepted", n_acc - a0, 5);
      check("t3_done", done_count, 7);

      // 4: stall timeout and clear
      tick();
      w0 = n_wcyc;
      m_waitrequest = 1;
      drive(1, 8'h20, 32'hCAFEF00D);
      tick();
      cmd_valid = 0;
      wait_idle(30);
      check("t4_write_cycles", n_wcyc - w0, TIMEOUT);
      check("t4_err", timeout_err, 1);
      check("t4_done", done_count, 7);
      tick();
      m_waitrequest = 0;
      clr_err = 1;
      tick();
      clr_err = 0;
      @(negedge clk);
      check("t4_err_cleared", timeout_err, 0);

      // 5: asynchronous reset in the middle of a stalled write with 2 queued
      tick();
      m_waitrequest = 1;
      for (int i = 0; i < 3; i++) begin
         drive(1, 8'h80 + 8'(i), 32'hA000_0000 + 32'(i));
         tick();
      end
      cmd_valid = 0;
      @(negedge clk);
      check("t5_writing", m_write, 1);
      @(posedge clk);
      #3;
      mon_en = 0;
      rst_in = 1;
      #1;
      check("t5_async_m_write", m_write, 0);
      check("t5_async_done", done_count, 0);
      check("t5_async_busy", busy, 0);
      @(posedge clk);
      #1;
      rst_in = 0;
      m_waitrequest = 0;
      model_reset();
      mon_en = 1;
      w0 = n_wcyc;
      repeat (5) tick();
      @(negedge clk);
      check("t5_no_writes", n_wcyc - w0, 0);
      check("t5_done", done_count, 0);
      check("t5_ready", cmd_ready, 1);

      // 6: 17 writes wrap a 4-bit counter to 1
      tick();
      a0 = n_acc;
      guard = 0;
      while ((n_acc - a0) < 17 && guard < 100) begin
         drive(1, 8'($urandom), $urandom);
         tick();
         guard++;
      end
      cmd_valid = 0;
      wait_idle(40);
      check("t6_accepted", n_acc - a0, 17);
      check("t6_done_wrap", done_count, 1);

      // randomized traffic with occasional long stalls
      tick();
      burst = 0;
      for (int c = 0; c < 600; c++) begin
         drive($urandom_range(0, 99) < 55, 8'($urandom), $urandom);
         if (burst > 0) begin
            m_waitrequest = 1;
            burst--;
         end else begin
            m_waitrequest = $urandom_range(0, 99) < 30;
            if ($urandom_range(0, 99) < 3) burst = $urandom_range(6, 12);
         end
         clr_err = $urandom_range(0, 99) < 4;
         tick();
      end
      drive(0, '0, '0);
      m_waitrequest = 0;
      clr_err = 0;
      wait_idle(100);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
